// File: rtl/if_fetch_pkg.sv
// Shared types for the IF/ID boundary.
package if_fetch_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ifid_data_t;

endpackage

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, keeps at most one imem request outstanding and
// presents a registered {pc, inst} entry plus IF trap flags to the IF/ID register.
module if_fetch_unit
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] INST_NOP = 32'h0000_0013
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_stall,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_imem_err,
    output ifid_data_t  o_data,
    output logic        o_valid,
    output logic        o_t_inst_addr_misaligned,
    output logic        o_t_inst_access_fault
);

    typedef enum logic [2:0] {
        SReq,
        SWait,
        SHold,
        STrap,
        SKill
    } state_e;

    state_e     state_q;
    logic [31:0] pc_q;
    ifid_data_t data_q;
    logic       valid_q;
    logic       misaligned_q;
    logic       access_fault_q;

    logic pc_aligned;

    assign pc_aligned  = (pc_q[1:0] == 2'b00);
    // Not gated by i_redirect: a same-cycle grant must be tracked via SKill.
    assign o_imem_req  = (state_q == SReq) && pc_aligned;
    assign o_imem_addr = pc_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q        <= SReq;
            pc_q           <= RESET_PC;
            data_q         <= '{pc: 32'h0, inst: INST_NOP};
            valid_q        <= 1'b0;
            misaligned_q   <= 1'b0;
            access_fault_q <= 1'b0;
        end else if (i_redirect) begin
            pc_q           <= i_redirect_pc;
            valid_q        <= 1'b0;
            data_q.inst    <= INST_NOP;
            misaligned_q   <= 1'b0;
            access_fault_q <= 1'b0;
            // Go to SKill only while a granted request still owes a response.
            unique case (state_q)
                SReq:        state_q <= (o_imem_req && i_imem_gnt) ? SKill : SReq;
                SWait, SKill: state_q <= i_imem_rvalid ? SReq : SKill;
                default:     state_q <= SReq;
            endcase
        end else begin
            unique case (state_q)
                SReq: begin
                    if (!pc_aligned) begin
                        data_q       <= '{pc: pc_q, inst: INST_NOP};
                        misaligned_q <= 1'b1;
                        valid_q      <= 1'b1;
                        state_q      <= SHold;
                    end else if (i_imem_gnt) begin
                        state_q <= SWait;
                    end
                end
                SWait: begin
                    if (i_imem_rvalid) begin
                        data_q.pc      <= pc_q;
                        data_q.inst    <= i_imem_err ? INST_NOP : i_imem_rdata;
                        access_fault_q <= i_imem_err;
                        valid_q        <= 1'b1;
                        state_q        <= SHold;
                    end
                end
                SHold: begin
                    if (!i_stall) begin
                        valid_q        <= 1'b0;
                        data_q.inst    <= INST_NOP;
                        misaligned_q   <= 1'b0;
                        access_fault_q <= 1'b0;
                        if (misaligned_q || access_fault_q) begin
                            state_q <= STrap;
                        end else begin
                            pc_q    <= pc_q + 32'd4;
                            state_q <= SReq;
                        end
                    end
                end
                STrap: state_q <= STrap;
                SKill: begin
                    if (i_imem_rvalid) begin
                        state_q <= SReq;
                    end
                end
                default: state_q <= SReq;
            endcase
        end
    end

    assign o_data                   = data_q;
    assign o_valid                  = valid_q;
    assign o_t_inst_addr_misaligned = misaligned_q;
    assign o_t_inst_access_fault    = access_fault_q;

endmodule
